// File: rtl/pri_enc32_pkg.sv
// -----------------------------------------------------------------------------
// pri_enc32_pkg
//   Shared definitions for the 32-source pending-event priority encoder.
//   Holds the fixed geometry of the selector, the grant FSM state encoding
//   and a small one-hot helper used by the pending-register clear path.
// -----------------------------------------------------------------------------
package pri_enc32_pkg;

  // Fixed geometry: 32 sources, split into 4 groups of 8.
  localparam int unsigned N_REQ = 32;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned GRP_W = 8;
  localparam int unsigned N_GRP = 4;

  // Grant FSM. The encodings are fixed so that waveform viewers and any
  // other block decoding the state see the same values.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  // One-hot vector with bit i set.
  function automatic logic [N_REQ-1:0] onehot32(input logic [IDX_W-1:0] i);
    return {{(N_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

endpackage : pri_enc32_pkg

// File: rtl/pri_enc32_enc8.sv
// -----------------------------------------------------------------------------
// pri_enc8
//   8-to-3 priority encoder with group-active output, in the spirit of the
//   74x148 but with active-high signals and bit 0 as the highest priority.
//
//   Ports
//     in   [7:0]  request lines, bit 0 wins
//     enc  [2:0]  binary index of the lowest set bit (0 when none set)
//     gs          group active: at least one input is set
// -----------------------------------------------------------------------------
module pri_enc8 (
  input  logic [7:0] in,
  output logic [2:0] enc,
  output logic       gs
);

  assign gs = |in;

  // NOTE: every variable written in always_comb gets a default first; without
  // it a path that assigns nothing makes synthesis infer a latch.
  always_comb begin
    enc = 3'd0;
    // Walk from the lowest priority up so the last hit is the lowest index.
    for (int i = 7; i >= 0; i--) begin
      if (in[i]) enc = 3'(i);
    end
  end

endmodule : pri_enc8

// File: rtl/pri_enc32.sv
// -----------------------------------------------------------------------------
// pri_enc32
//   Captures event pulses from 32 sources into a pending register and hands
//   them out one at a time, lowest index first, through a valid/ready port.
//
//   Ports
//     clk          clock, all state changes on the rising edge
//     rst          synchronous active-high reset
//     req   [31:0] event pulses, bit i marks source i pending
//     mask  [31:0] bit i hides pending bit i from selection (does not clear it)
//     valid        idx holds a selected pending source
//     ready        consumer accepts idx when valid && ready at an edge
//     idx   [4:0]  index of the presented source; stale while valid = 0
//     pend  [31:0] pending register, for observation
//
//   Behaviour
//     IDLE    : any eligible bit at an edge -> latch its index, go PRESENT.
//     PRESENT : idx frozen until ready; the accepting edge clears pend[idx]
//               and returns to IDLE, so grants are at most one per two cycles.
//     A new pulse on the acknowledged bit in the same edge wins over the clear.
// -----------------------------------------------------------------------------
module pri_enc32
  import pri_enc32_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     mask,
  output logic                 valid,
  input  logic                 ready,
  output logic [IDX_W-1:0]     idx,
  output logic [N_REQ-1:0]     pend
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [N_REQ-1:0]     pend_q, pend_d;
  logic [IDX_W-1:0]     idx_q;

  // ---------------------------------------------------------------------------
  // Selection: four 8-bit encoders plus a group priority stage.
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0]          eligible;
  logic [N_GRP-1:0][2:0]     local_idx;
  logic [N_GRP-1:0]          grp_act;
  logic [1:0]                grp;
  logic                      any_eligible;
  logic [IDX_W-1:0]          sel_idx;

  assign eligible = pend_q & ~mask;

  for (genvar g = 0; g < N_GRP; g++) begin : g_enc
    pri_enc8 u_enc8 (
      .in  (eligible[g*GRP_W +: GRP_W]),
      .enc (local_idx[g]),
      .gs  (grp_act[g])
    );
  end

  assign any_eligible = |grp_act;

  // Lowest active group wins, matching the in-group priority direction.
  always_comb begin
    grp = 2'd0;
    if      (grp_act[0]) grp = 2'd0;
    else if (grp_act[1]) grp = 2'd1;
    else if (grp_act[2]) grp = 2'd2;
    else if (grp_act[3]) grp = 2'd3;
  end

  assign sel_idx = {grp, local_idx[grp]};

  // ---------------------------------------------------------------------------
  // Grant FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  logic load_idx;
  logic ack;

  always_comb begin
    state_d  = state_q;
    load_idx = 1'b0;
    ack      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_eligible) begin
          state_d  = ST_PRESENT;
          load_idx = 1'b1;
        end
      end
      ST_PRESENT: begin
        // Presented index stays put regardless of new requests or mask.
        if (ready) begin
          state_d = ST_IDLE;
          ack     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear is applied before the OR so a same-edge pulse keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (ack) pend_d = pend_d & ~onehot32(idx_q);
    pend_d = pend_d | req;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (load_idx) idx_q <= sel_idx;
    end
  end

  assign valid = (state_q == ST_PRESENT);
  assign idx   = idx_q;
  assign pend  = pend_q;

endmodule : pri_enc32

// File: tb/tb_pri_enc32.sv
// -----------------------------------------------------------------------------
// tb_pri_enc32
//   Directed self-checking bench for pri_enc32. Expected grant indices are
//   queued when the stimulus that causes them is driven and popped when the
//   DUT presents a grant. Inputs change and outputs are sampled 1 ns after
//   the rising edge.
// -----------------------------------------------------------------------------
module tb_pri_enc32;

  logic        clk;
  logic        rst;
  logic [31:0] req;
  logic [31:0] mask;
  logic        valid;
  logic        ready;
  logic [4:0]  idx;
  logic [31:0] pend;

  int unsigned n_pass;
  int unsigned n_total;
  int          exp_q[$];

  pri_enc32 dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .mask  (mask),
    .valid (valid),
    .ready (ready),
    .idx   (idx),
    .pend  (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound; the directed sequence ends far earlier.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // A grant must be on the port now, carrying the oldest queued index.
  task automatic check_grant(input string tag);
    int e;
    check({tag, "_valid"}, {31'd0, valid}, 32'd1);
    if (exp_q.size() == 0) begin
      n_total++;
      $error("FAIL %s_sb: grant idx %0d with empty scoreboard", tag, idx);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_idx"}, {27'd0, idx}, 32'(e));
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst   = 1'b1;
    req   = '0;
    mask  = '0;
    ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_pend",  pend, 32'd0);
    check("rst_idx",   {27'd0, idx}, 32'd0);
    rst = 1'b0;

    // Single pulse on source 5: pending at k, valid at k+1, ack clears.
    req = 32'h1 << 5;
    exp_q.push_back(5);
    tick();
    req = '0;
    check("s5_pend", pend, 32'h0000_0020);
    check("s5_novalid", {31'd0, valid}, 32'd0);
    tick();
    check_grant("s5");
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("s5_ack_pend",  pend, 32'd0);
    check("s5_ack_valid", {31'd0, valid}, 32'd0);
    check("s5_idx_hold",  {27'd0, idx}, 32'd5);

    // Three sources at once, ready held: 0, 4, 31 two cycles apart.
    req = 32'h8000_0011;
    exp_q.push_back(0);
    exp_q.push_back(4);
    exp_q.push_back(31);
    ready = 1'b1;
    tick();
    req = '0;
    tick();
    check_grant("m0");
    tick();
    check("m0_gap", {31'd0, valid}, 32'd0);
    tick();
    check_grant("m4");
    tick();
    check("m4_gap", {31'd0, valid}, 32'd0);
    tick();
    check_grant("m31");
    tick();
    check("m_pend", pend, 32'd0);
    check("m_valid", {31'd0, valid}, 32'd0);
    ready = 1'b0;

    // Grant 9 held while a higher-priority request arrives.
    req = 32'h1 << 9;
    exp_q.push_back(9);
    tick();
    req = '0;
    tick();
    check_grant("h9");
    req = 32'h1 << 2;
    exp_q.push_back(2);
    tick();
    req = '0;
    check("h9_hold_idx",   {27'd0, idx}, 32'd9);
    check("h9_hold_valid", {31'd0, valid}, 32'd1);
    tick();
    check("h9_hold_idx2",  {27'd0, idx}, 32'd9);
    check("h9_pend", pend, 32'h0000_0204);
    ready = 1'b1;
    tick();
    check("h9_ack_pend", pend, 32'h0000_0004);
    check("h9_ack_valid", {31'd0, valid}, 32'd0);
    tick();
    check_grant("h2");
    tick();
    check("h2_ack_pend", pend, 32'd0);
    ready = 1'b0;

    // Fully masked: nothing presented, bit stays pending until unmasked.
    mask = 32'hFFFF_FFFF;
    req  = 32'h1 << 3;
    exp_q.push_back(3);
    tick();
    req = '0;
    tick();
    tick();
    check("mk_valid", {31'd0, valid}, 32'd0);
    check("mk_pend", pend, 32'h0000_0008);
    mask = '0;
    tick();
    check_grant("mk3");
    ready = 1'b1;
    tick();
    check("mk_ack_pend", pend, 32'd0);
    ready = 1'b0;

    // Partial mask selects the next eligible source; mask change in PRESENT
    // leaves the grant alone.
    mask = 32'h0000_0002;
    req  = 32'h0000_0042;
    exp_q.push_back(6);
    tick();
    req = '0;
    tick();
    check_grant("pm6");
    mask = 32'h0000_0040;
    tick();
    check("pm6_hold", {27'd0, idx}, 32'd6);
    check("pm6_hold_valid", {31'd0, valid}, 32'd1);
    mask  = '0;
    ready = 1'b1;
    exp_q.push_back(1);
    tick();
    check("pm_ack_pend", pend, 32'h0000_0002);
    tick();
    check_grant("pm1");
    tick();
    check("pm_pend", pend, 32'd0);
    ready = 1'b0;

    // Same-edge pulse on the acknowledged bit: set wins, re-granted.
    req = 32'h1 << 7;
    exp_q.push_back(7);
    tick();
    req = '0;
    tick();
    check_grant("r7a");
    req   = 32'h1 << 7;
    ready = 1'b1;
    exp_q.push_back(7);
    tick();
    req = '0;
    check("r7_pend", pend, 32'h0000_0080);
    check("r7_gap", {31'd0, valid}, 32'd0);
    tick();
    check_grant("r7b");
    tick();
    check("r7_final_pend", pend, 32'd0);
    ready = 1'b0;

    // Reset during PRESENT discards everything, ack included.
    req = 32'h0000_0F00;
    tick();
    req = '0;
    tick();
    check("rp_valid", {31'd0, valid}, 32'd1);
    check("rp_idx", {27'd0, idx}, 32'd8);
    rst   = 1'b1;
    ready = 1'b1;
    req   = 32'h0000_1000;
    tick();
    rst   = 1'b0;
    ready = 1'b0;
    req   = '0;
    check("rp_pend", pend, 32'd0);
    check("rp_rvalid", {31'd0, valid}, 32'd0);
    check("rp_ridx", {27'd0, idx}, 32'd0);
    tick();
    check("rp_quiet", {31'd0, valid}, 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pri_enc32
